// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: groups the pipeline/fetch/CP0 signals of the exception sequencer.
//   Exception request : exc_valid_i, excode_i, pc_i, bd_i, badvaddr_i
//   Interrupts / ERET : int_i, eret_i
//   MTC0 write        : mtc0_we_i, mtc0_addr_i, mtc0_data_i
//   Fetch redirect    : redirect_valid_o, redirect_pc_o, redirect_ready_i
//   Status            : flush_o, busy_o
//   CP0 registers     : epc_o, cause_o, status_o, badvaddr_o
// Modport master is the pipeline side; modport slave is exc_ctrl.
interface exc_ctrl_if;
    logic        exc_valid_i;
    logic [4:0]  excode_i;
    logic [31:0] pc_i;
    logic        bd_i;
    logic [31:0] badvaddr_i;
    logic [5:0]  int_i;
    logic        eret_i;
    logic        mtc0_we_i;
    logic [4:0]  mtc0_addr_i;
    logic [31:0] mtc0_data_i;
    logic        redirect_ready_i;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;
    logic [31:0] epc_o;
    logic [31:0] cause_o;
    logic [31:0] status_o;
    logic [31:0] badvaddr_o;

    modport master (
        output exc_valid_i, excode_i, pc_i, bd_i, badvaddr_i, int_i, eret_i,
               mtc0_we_i, mtc0_addr_i, mtc0_data_i, redirect_ready_i,
        input  flush_o, redirect_valid_o, redirect_pc_o, busy_o,
               epc_o, cause_o, status_o, badvaddr_o
    );

    modport slave (
        input  exc_valid_i, excode_i, pc_i, bd_i, badvaddr_i, int_i, eret_i,
               mtc0_we_i, mtc0_addr_i, mtc0_data_i, redirect_ready_i,
        output flush_o, redirect_valid_o, redirect_pc_o, busy_o,
               epc_o, cause_o, status_o, badvaddr_o
    );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: CP0 exception sequencer.
//   Takes a memory-stage exception, a pending hardware interrupt or an ERET,
//   updates EPC/Cause/Status/BadVAddr, pulses flush_o for one cycle and then
//   holds a redirect to the exception vector (or EPC for ERET) until fetch
//   accepts it. MTC0 writes to Status/EPC are accepted in any state.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - exc_ctrl_if.slave (request, redirect and CP0 register signals)
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter logic [4:0]  ADDR_STATUS = 5'd12,
    parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
    input  logic       clk,
    input  logic       rst,
    exc_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t      state_r, next_state_s;
    logic        flush_r, flush_s;
    logic        redir_valid_r, redir_valid_s;
    logic [31:0] redir_pc_r, redir_pc_s;
    logic        busy_r;
    logic [31:0] epc_r, epc_s;
    logic        bd_r, bd_s;
    logic [4:0]  excode_r, excode_s;
    logic [5:0]  im_r, im_s;
    logic        exl_r, exl_s;
    logic        ie_r, ie_s;
    logic [31:0] badvaddr_r, badvaddr_s;
    logic [5:0]  int_q_r;
    logic        int_pend_s;
    logic        take_s;
    logic [4:0]  take_code_s;

    // Interrupt is pending only when unmasked, globally enabled and not already in an exception.
    assign int_pend_s = (|(int_q_r & im_r)) & ie_r & ~exl_r;

    // Next-state, output and CP0 field update logic; MTC0 is applied first so a same-cycle event overrides it per field.
    always_comb begin
        next_state_s  = state_r;
        flush_s       = 1'b0;
        redir_valid_s = 1'b0;
        redir_pc_s    = redir_pc_r;
        epc_s         = epc_r;
        bd_s          = bd_r;
        excode_s      = excode_r;
        im_s          = im_r;
        exl_s         = exl_r;
        ie_s          = ie_r;
        badvaddr_s    = badvaddr_r;
        take_s        = 1'b0;
        take_code_s   = 5'd0;

        if (bus.mtc0_we_i) begin
            if (bus.mtc0_addr_i == ADDR_STATUS) begin
                im_s  = bus.mtc0_data_i[15:10];
                exl_s = bus.mtc0_data_i[1];
                ie_s  = bus.mtc0_data_i[0];
            end else if (bus.mtc0_addr_i == ADDR_EPC) begin
                epc_s = bus.mtc0_data_i;
            end else begin
                epc_s = epc_r;
            end
        end else begin
            epc_s = epc_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (bus.exc_valid_i) begin
                    take_s      = 1'b1;
                    take_code_s = bus.excode_i;
                    if ((bus.excode_i == 5'd4) || (bus.excode_i == 5'd5)) begin
                        badvaddr_s = bus.badvaddr_i;
                    end else begin
                        badvaddr_s = badvaddr_r;
                    end
                end else if (int_pend_s) begin
                    take_s      = 1'b1;
                    take_code_s = 5'd0;
                end else if (bus.eret_i) begin
                    exl_s        = 1'b0;
                    redir_pc_s   = epc_r;
                    flush_s      = 1'b1;
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_IDLE;
                end

                if (take_s) begin
                    // A nested exception (EXL already set) keeps the original return point.
                    if (!exl_r) begin
                        epc_s = bus.bd_i ? (bus.pc_i - 32'd4) : bus.pc_i;
                        bd_s  = bus.bd_i;
                    end else begin
                        bd_s  = bd_r;
                    end
                    excode_s     = take_code_s;
                    exl_s        = 1'b1;
                    redir_pc_s   = EXC_VECTOR;
                    flush_s      = 1'b1;
                    next_state_s = ST_FLUSH;
                end else begin
                    excode_s = excode_r;
                end
            end
            ST_FLUSH: begin
                redir_valid_s = 1'b1;
                next_state_s  = ST_REDIR;
            end
            ST_REDIR: begin
                if (bus.redirect_ready_i) begin
                    redir_valid_s = 1'b0;
                    next_state_s  = ST_IDLE;
                end else begin
                    redir_valid_s = 1'b1;
                    next_state_s  = ST_REDIR;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs, CP0 fields and the interrupt-line sampler.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_r       <= 1'b0;
            redir_valid_r <= 1'b0;
            redir_pc_r    <= 32'd0;
            busy_r        <= 1'b0;
            epc_r         <= 32'd0;
            bd_r          <= 1'b0;
            excode_r      <= 5'd0;
            im_r          <= 6'd0;
            exl_r         <= 1'b0;
            ie_r          <= 1'b0;
            badvaddr_r    <= 32'd0;
            int_q_r       <= 6'd0;
        end else begin
            flush_r       <= flush_s;
            redir_valid_r <= redir_valid_s;
            redir_pc_r    <= redir_pc_s;
            busy_r        <= (next_state_s != ST_IDLE);
            epc_r         <= epc_s;
            bd_r          <= bd_s;
            excode_r      <= excode_s;
            im_r          <= im_s;
            exl_r         <= exl_s;
            ie_r          <= ie_s;
            badvaddr_r    <= badvaddr_s;
            int_q_r       <= bus.int_i;
        end
    end

    assign bus.flush_o          = flush_r;
    assign bus.redirect_valid_o = redir_valid_r;
    assign bus.redirect_pc_o    = redir_pc_r;
    assign bus.busy_o           = busy_r;
    assign bus.epc_o            = epc_r;
    assign bus.cause_o          = {bd_r, 15'd0, int_q_r, 3'd0, excode_r, 2'd0};
    assign bus.status_o         = {16'd0, im_r, 8'd0, exl_r, ie_r};
    assign bus.badvaddr_o       = badvaddr_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    exc_ctrl_if bus ();

    exc_ctrl #(
        .EXC_VECTOR  (VEC),
        .ADDR_STATUS (5'd12),
        .ADDR_EPC    (5'd14)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.exc_valid_i      = 1'b0;
        bus.excode_i         = 5'd0;
        bus.pc_i             = 32'd0;
        bus.bd_i             = 1'b0;
        bus.badvaddr_i       = 32'd0;
        bus.int_i            = 6'd0;
        bus.eret_i           = 1'b0;
        bus.mtc0_we_i        = 1'b0;
        bus.mtc0_addr_i      = 5'd0;
        bus.mtc0_data_i      = 32'd0;
        bus.redirect_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total_cnt++; if (bus.flush_o !== 1'b0) $display("FAIL rst_flush: got %b want 0", bus.flush_o); else pass_cnt++;
        total_cnt++; if (bus.redirect_valid_o !== 1'b0) $display("FAIL rst_rv: got %b want 0", bus.redirect_valid_o); else pass_cnt++;
        total_cnt++; if (bus.redirect_pc_o !== 32'd0) $display("FAIL rst_rpc: got %h want 0", bus.redirect_pc_o); else pass_cnt++;
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy_o); else pass_cnt++;
        total_cnt++; if (bus.epc_o !== 32'd0) $display("FAIL rst_epc: got %h want 0", bus.epc_o); else pass_cnt++;
        total_cnt++; if (bus.cause_o !== 32'd0) $display("FAIL rst_cause: got %h want 0", bus.cause_o); else pass_cnt++;
        total_cnt++; if (bus.status_o !== 32'd0) $display("FAIL rst_status: got %h want 0", bus.status_o); else pass_cnt++;
        total_cnt++; if (bus.badvaddr_o !== 32'd0) $display("FAIL rst_badvaddr: got %h want 0", bus.badvaddr_o); else pass_cnt++;
    endtask

    task automatic test_exception();
        bus.exc_valid_i = 1'b1;
        bus.excode_i    = 5'd12;
        bus.pc_i        = 32'h8000_0100;
        bus.bd_i        = 1'b0;
        bus.badvaddr_i  = 32'h1234_5678;
        tick();
        bus.exc_valid_i = 1'b0;
        total_cnt++; if (bus.epc_o !== 32'h8000_0100) $display("FAIL ov_epc: got %h want 80000100", bus.epc_o); else pass_cnt++;
        total_cnt++; if (bus.cause_o[6:2] !== 5'd12) $display("FAIL ov_excode: got %0d want 12", bus.cause_o[6:2]); else pass_cnt++;
        total_cnt++; if (bus.status_o[1] !== 1'b1) $display("FAIL ov_exl: got %b want 1", bus.status_o[1]); else pass_cnt++;
        total_cnt++; if (bus.flush_o !== 1'b1) $display("FAIL ov_flush: got %b want 1", bus.flush_o); else pass_cnt++;
        total_cnt++; if (bus.busy_o !== 1'b1) $display("FAIL ov_busy: got %b want 1", bus.busy_o); else pass_cnt++;
        total_cnt++; if (bus.badvaddr_o !== 32'd0) $display("FAIL ov_badvaddr: got %h want 0", bus.badvaddr_o); else pass_cnt++;
        tick();
        total_cnt++; if (bus.flush_o !== 1'b0) $display("FAIL ov_flush_once: got %b want 0", bus.flush_o); else pass_cnt++;
        total_cnt++; if (bus.redirect_valid_o !== 1'b1) $display("FAIL ov_rv: got %b want 1", bus.redirect_valid_o); else pass_cnt++;
        total_cnt++; if (bus.redirect_pc_o !== VEC) $display("FAIL ov_rpc: got %h want %h", bus.redirect_pc_o, VEC); else pass_cnt++;
        bus.redirect_ready_i = 1'b1;
        tick();
        bus.redirect_ready_i = 1'b0;
        total_cnt++; if (bus.redirect_valid_o !== 1'b0) $display("FAIL ov_rv_drop: got %b want 0", bus.redirect_valid_o); else pass_cnt++;
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL ov_idle: got %b want 0", bus.busy_o); else pass_cnt++;
    endtask

    task automatic test_adel_delay_slot();
        // Clear EXL so the new exception records EPC/BD.
        bus.mtc0_we_i   = 1'b1;
        bus.mtc0_addr_i = 5'd12;
        bus.mtc0_data_i = 32'd0;
        tick();
        bus.mtc0_we_i   = 1'b0;
        total_cnt++; if (bus.status_o !== 32'd0) $display("FAIL adel_clr_status: got %h want 0", bus.status_o); else pass_cnt++;
        bus.exc_valid_i = 1'b1;
        bus.excode_i    = 5'd4;
        bus.pc_i        = 32'h8000_0204;
        bus.bd_i        = 1'b1;
        bus.badvaddr_i  = 32'h0000_0003;
        tick();
        bus.exc_valid_i = 1'b0;
        bus.bd_i        = 1'b0;
        total_cnt++; if (bus.epc_o !== 32'h8000_0200) $display("FAIL adel_epc: got %h want 80000200", bus.epc_o); else pass_cnt++;
        total_cnt++; if (bus.cause_o[31] !== 1'b1) $display("FAIL adel_bd: got %b want 1", bus.cause_o[31]); else pass_cnt++;
        total_cnt++; if (bus.cause_o[6:2] !== 5'd4) $display("FAIL adel_excode: got %0d want 4", bus.cause_o[6:2]); else pass_cnt++;
        total_cnt++; if (bus.badvaddr_o !== 32'h0000_0003) $display("FAIL adel_badvaddr: got %h want 3", bus.badvaddr_o); else pass_cnt++;
        bus.redirect_ready_i = 1'b1;
        tick();
        tick();
        bus.redirect_ready_i = 1'b0;
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL adel_idle: got %b want 0", bus.busy_o); else pass_cnt++;
    endtask

    task automatic test_interrupt();
        bus.mtc0_we_i   = 1'b1;
        bus.mtc0_addr_i = 5'd12;
        bus.mtc0_data_i = 32'h0000_0401;
        tick();
        bus.mtc0_we_i   = 1'b0;
        total_cnt++; if (bus.status_o !== 32'h0000_0401) $display("FAIL int_status: got %h want 00000401", bus.status_o); else pass_cnt++;
        bus.int_i = 6'b000001;
        bus.pc_i  = 32'h8000_0400;
        tick();
        total_cnt++; if (bus.cause_o[15:10] !== 6'b000001) $display("FAIL int_ip: got %b want 000001", bus.cause_o[15:10]); else pass_cnt++;
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL int_not_yet: got %b want 0", bus.busy_o); else pass_cnt++;
        tick();
        total_cnt++; if (bus.flush_o !== 1'b1) $display("FAIL int_flush: got %b want 1", bus.flush_o); else pass_cnt++;
        total_cnt++; if (bus.cause_o[6:2] !== 5'd0) $display("FAIL int_excode: got %0d want 0", bus.cause_o[6:2]); else pass_cnt++;
        total_cnt++; if (bus.status_o[1] !== 1'b1) $display("FAIL int_exl: got %b want 1", bus.status_o[1]); else pass_cnt++;
        total_cnt++; if (bus.epc_o !== 32'h8000_0400) $display("FAIL int_epc: got %h want 80000400", bus.epc_o); else pass_cnt++;
        total_cnt++; if (bus.badvaddr_o !== 32'h0000_0003) $display("FAIL int_badvaddr: got %h want 3", bus.badvaddr_o); else pass_cnt++;
        tick();
        total_cnt++; if (bus.redirect_pc_o !== VEC) $display("FAIL int_rpc: got %h want %h", bus.redirect_pc_o, VEC); else pass_cnt++;
        bus.redirect_ready_i = 1'b1;
        tick();
        bus.redirect_ready_i = 1'b0;
        // int_i still high but EXL=1 masks it.
        tick();
        tick();
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL int_masked_busy: got %b want 0", bus.busy_o); else pass_cnt++;
        total_cnt++; if (bus.flush_o !== 1'b0) $display("FAIL int_masked_flush: got %b want 0", bus.flush_o); else pass_cnt++;
        bus.int_i = 6'd0;
    endtask

    task automatic test_eret_backpressure();
        bus.mtc0_we_i   = 1'b1;
        bus.mtc0_addr_i = 5'd14;
        bus.mtc0_data_i = 32'h8000_0300;
        tick();
        bus.mtc0_we_i   = 1'b0;
        total_cnt++; if (bus.epc_o !== 32'h8000_0300) $display("FAIL eret_mtc0_epc: got %h want 80000300", bus.epc_o); else pass_cnt++;
        bus.eret_i = 1'b1;
        tick();
        bus.eret_i = 1'b0;
        total_cnt++; if (bus.status_o[1] !== 1'b0) $display("FAIL eret_exl: got %b want 0", bus.status_o[1]); else pass_cnt++;
        total_cnt++; if (bus.flush_o !== 1'b1) $display("FAIL eret_flush: got %b want 1", bus.flush_o); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++; if (bus.redirect_valid_o !== 1'b1) $display("FAIL eret_rv_hold[%0d]: got %b want 1", i, bus.redirect_valid_o); else pass_cnt++;
            total_cnt++; if (bus.redirect_pc_o !== 32'h8000_0300) $display("FAIL eret_rpc_hold[%0d]: got %h want 80000300", i, bus.redirect_pc_o); else pass_cnt++;
        end
        bus.redirect_ready_i = 1'b1;
        tick();
        bus.redirect_ready_i = 1'b0;
        total_cnt++; if (bus.redirect_valid_o !== 1'b0) $display("FAIL eret_rv_drop: got %b want 0", bus.redirect_valid_o); else pass_cnt++;
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL eret_idle: got %b want 0", bus.busy_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // Status still IM[10]=1, IE=1, EXL=0: make an interrupt pending.
        bus.int_i = 6'b000001;
        tick();
        bus.exc_valid_i = 1'b1;
        bus.excode_i    = 5'd8;
        bus.pc_i        = 32'h8000_0500;
        bus.mtc0_we_i   = 1'b1;
        bus.mtc0_addr_i = 5'd14;
        bus.mtc0_data_i = 32'hDEAD_BEEF;
        tick();
        bus.mtc0_we_i   = 1'b0;
        bus.int_i       = 6'd0;
        total_cnt++; if (bus.cause_o[6:2] !== 5'd8) $display("FAIL pri_excode: got %0d want 8", bus.cause_o[6:2]); else pass_cnt++;
        total_cnt++; if (bus.epc_o !== 32'h8000_0500) $display("FAIL pri_epc: got %h want 80000500", bus.epc_o); else pass_cnt++;
        total_cnt++; if (bus.flush_o !== 1'b1) $display("FAIL pri_flush: got %b want 1", bus.flush_o); else pass_cnt++;
        // Second request while busy must be ignored.
        bus.excode_i = 5'd10;
        bus.pc_i     = 32'h8000_0600;
        tick();
        tick();
        bus.exc_valid_i = 1'b0;
        total_cnt++; if (bus.redirect_valid_o !== 1'b1) $display("FAIL busy_rv: got %b want 1", bus.redirect_valid_o); else pass_cnt++;
        total_cnt++; if (bus.cause_o[6:2] !== 5'd8) $display("FAIL busy_excode: got %0d want 8", bus.cause_o[6:2]); else pass_cnt++;
        total_cnt++; if (bus.epc_o !== 32'h8000_0500) $display("FAIL busy_epc: got %h want 80000500", bus.epc_o); else pass_cnt++;
        bus.redirect_ready_i = 1'b1;
        tick();
        bus.redirect_ready_i = 1'b0;
        tick();
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL busy_idle: got %b want 0", bus.busy_o); else pass_cnt++;
        total_cnt++; if (bus.flush_o !== 1'b0) $display("FAIL busy_no_retake: got %b want 0", bus.flush_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid_sequence();
        bus.exc_valid_i = 1'b1;
        bus.excode_i    = 5'd13;
        bus.pc_i        = 32'h8000_0700;
        tick();
        bus.exc_valid_i = 1'b0;
        tick();
        total_cnt++; if (bus.redirect_valid_o !== 1'b1) $display("FAIL mid_rv_before: got %b want 1", bus.redirect_valid_o); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++; if (bus.redirect_valid_o !== 1'b0) $display("FAIL mid_rv: got %b want 0", bus.redirect_valid_o); else pass_cnt++;
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.busy_o); else pass_cnt++;
        total_cnt++; if (bus.status_o !== 32'd0) $display("FAIL mid_status: got %h want 0", bus.status_o); else pass_cnt++;
        total_cnt++; if (bus.epc_o !== 32'd0) $display("FAIL mid_epc: got %h want 0", bus.epc_o); else pass_cnt++;
        tick();
        total_cnt++; if (bus.flush_o !== 1'b0) $display("FAIL mid_flush: got %b want 0", bus.flush_o); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        idle_inputs();
        test_reset();
        test_exception();
        test_adel_delay_slot();
        test_interrupt();
        test_eret_backpressure();
        test_back_to_back();
        test_reset_mid_sequence();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- CP0 exception sequencer between the pipeline and the CP0 register file.
- Accepts an exception request carrying a 5-bit excode from the memory stage, or a pending hardware interrupt, and updates EPC/Cause/Status/BadVAddr.
- Sequences the pipeline flush and PC redirect to the exception vector.
- Handles ERET return, and MTC0 writes to Status/EPC.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception/interrupt.
- ADDR_STATUS, 5'd12, CP0 register number of Status.
- ADDR_EPC, 5'd14, CP0 register number of EPC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- exc_valid_i  in  1  memory-stage instruction raises an exception.
- excode_i  in  5  MIPS ExcCode: 4 AdEL, 5 AdES, 6 IBE, 7 DBE, 8 Sys, 9 Bp, 10 RI, 11 CpU, 12 Ov, 13 Tr.
- pc_i  in  32  PC of the memory-stage instruction.
- bd_i  in  1  that instruction sits in a branch delay slot.
- badvaddr_i  in  32  faulting address, used for AdEL/AdES.
- int_i  in  6  hardware interrupt lines, level-sensitive.
- eret_i  in  1  memory-stage ERET.
- mtc0_we_i  in  1  MTC0 write strobe.
- mtc0_addr_i  in  5  MTC0 register number.
- mtc0_data_i  in  32  MTC0 data.
- redirect_ready_i  in  1  fetch accepts the redirect.
- flush_o  out  1  one-cycle pipeline flush.
- redirect_valid_o  out  1  redirect request.
- redirect_pc_o  out  32  redirect target.
- busy_o  out  1  sequencer not IDLE.
- epc_o  out  32  EPC.
- cause_o  out  32  Cause: [31] BD, [15:10] IP, [6:2] ExcCode, all other bits 0.
- status_o  out  32  Status: [15:10] IM, [1] EXL, [0] IE, all other bits 0.
- badvaddr_o  out  32  BadVAddr.

Behaviour:
- Reset (synchronous, active-high): state IDLE; flush_o=0, redirect_valid_o=0, redirect_pc_o=0, busy_o=0; EPC, BD, ExcCode, IM, EXL, IE, BadVAddr all 0.
- Reset mid-sequence: abandons the sequence and returns to IDLE on that edge.
- cause_o[15:10] is int_i registered one cycle (not reset-gated beyond the register clear).
- Interrupt pending: int_pend = |(int_q & IM) & IE & ~EXL, where int_q is the registered int_i.
- States: IDLE, FLUSH, REDIR.
- Event priority in IDLE: exc_valid_i, then int_pend, then eret_i. Only one event is taken per cycle.
- Exception taken at edge T (in IDLE):
  - if EXL=0: EPC = bd_i ? pc_i-4 : pc_i (32-bit wrap) and BD = bd_i; if EXL=1, EPC and BD are unchanged.
  - ExcCode = excode_i; EXL = 1.
  - BadVAddr = badvaddr_i only when excode_i is 4 or 5.
  - State goes to FLUSH.
- Interrupt taken: same register updates as an exception, with ExcCode=0 and BadVAddr unchanged.
- ERET taken at edge T: EXL = 0, then FLUSH. The redirect target is the EPC value at T.
- FLUSH: flush_o=1 for exactly one cycle (cycle T+1), then REDIR.
- REDIR:
  - redirect_valid_o=1; redirect_pc_o = EXC_VECTOR for exception/interrupt, or the latched EPC for ERET.
  - Held stable until a cycle with redirect_ready_i=1; on that edge go to IDLE and drop redirect_valid_o.
  - If redirect_ready_i is already 1 on entry, the redirect lasts one cycle.
- busy_o = (state != IDLE). exc_valid_i, eret_i and interrupts are ignored while busy; the pipeline is flushed, so no requests are lost.
- MTC0, accepted in any state:
  - ADDR_STATUS writes IM=data[15:10], EXL=data[1], IE=data[0].
  - ADDR_EPC writes EPC = data.
  - All other addresses are ignored.
  - If an exception, interrupt or ERET updates the same field in the same cycle, the event wins for that field.
- Minimum event-to-IDLE latency is 3 cycles (FLUSH, REDIR with ready, back to IDLE).

Test Plan:
- Reset, then exc_valid_i=1, excode_i=12, pc_i=32'h8000_0100, bd_i=0 -> next cycle epc_o=32'h8000_0100, cause_o[6:2]=12, status_o[1]=1, flush_o=1; following cycle redirect_valid_o=1, redirect_pc_o=32'hBFC00380; ready=1 -> IDLE.
- excode_i=4, bd_i=1, pc_i=32'h8000_0204, badvaddr_i=32'h0000_0003 -> epc_o=32'h8000_0200, cause_o[31]=1, badvaddr_o=32'h3.
- MTC0 Status=32'h0000_0401 (IM[10]=1, IE=1), then raise int_i[0] -> ExcCode=0, EXL=1, flush then redirect to vector; with EXL=1, a further int_i is not taken.
- ERET with EPC=32'h8000_0300 -> EXL cleared, flush_o pulse, redirect_pc_o=32'h8000_0300; redirect_ready_i held 0 for 4 cycles -> redirect_valid_o stays 1 with a stable PC for all 4 cycles.
- Same cycle: exc_valid_i (excode 8) + pending interrupt + MTC0 EPC write -> ExcCode=8 and EPC=pc_i (exception wins); a second exc_valid_i while busy_o=1 is ignored.
- rst asserted during REDIR -> next cycle IDLE, redirect_valid_o=0, status_o=0, epc_o=0.
